// File: rtl/ps2_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | ps2_pkg : scan-code constants, frame builder and sender states    |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
package ps2_pkg;

   localparam logic [7:0] PS2_EXT        = 8'hE0;
   localparam logic [7:0] PS2_BRK        = 8'hF0;
   localparam int         PS2_FRAME_BITS = 11;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      LOAD    = 3'd1,
      HIGH    = 3'd2,
      LOW     = 3'd3,
      GAP     = 3'd4,
      INHIBIT = 3'd5
   } ps2_state_t;

   // {stop, odd parity, data, start}; sent LSB first
   function automatic logic [10:0] ps2_frame(input logic [7:0] b);
      return {1'b1, ~^b, b, 1'b0};
   endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_bit_timer.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | ps2_bit_timer : HALF-cycle phase counter, reload on load          |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module ps2_bit_timer #(
   parameter int HALF = 5
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic done,
   output logic first
);

   localparam int W = $clog2(HALF) + 1;

   generate
      if (HALF < 2) begin : g_half_check
         $error("ps2_bit_timer: HALF must be at least 2");
      end
   endgenerate

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= W'(HALF - 1);
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done  = (cnt == '0);
   assign first = (cnt == W'(HALF - 1));

endmodule
`default_nettype wire

// File: rtl/ps2_key_sender.sv
`default_nettype none
// +-------------------------------------------------------------------+
// | ps2_key_sender : keyboard-side PS/2 transmitter for scan codes    |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module ps2_key_sender
   import ps2_pkg::*;
#(
   parameter int CLK_HZ   = 25000000,
   parameter int PS2_HZ   = 12500,
   parameter int GAP_BITS = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_valid,
   output logic       key_ready,
   input  logic [7:0] key_code,
   input  logic       key_ext,
   input  logic       key_break,
   input  logic       ps2clk_i,
   output logic       ps2clk_o,
   output logic       ps2data_o,
   output logic [7:0] abort_cnt
);

   localparam int HALF       = CLK_HZ / (2 * PS2_HZ);
   localparam int GAP_PHASES = GAP_BITS * 2;
   localparam int PH_W       = $clog2(GAP_PHASES + 2);

   ps2_state_t      state;
   logic [7:0]      q [3];
   logic [1:0]      q_len;
   logic [1:0]      q_ptr;
   logic [10:0]     sh;
   logic [3:0]      bit_idx;
   logic            low_seen;
   logic [PH_W-1:0] phase_cnt;

   logic       accept;
   logic       tmr_done;
   logic       tmr_first;
   logic       tmr_load;
   logic       to_inhibit;
   logic [7:0] head;

   assign accept     = key_valid & key_ready;
   assign to_inhibit = (state == HIGH) && !tmr_first && !ps2clk_i && low_seen;
   assign head       = (q_ptr == 2'd0) ? q[0] : (q_ptr == 2'd1) ? q[1] : q[2];

   // Every phase entry reloads the timer; INHIBIT also restarts it on any low sample
   always_comb begin
      tmr_load = 1'b0;
      case (state)
         LOAD:          tmr_load = 1'b1;
         HIGH:          tmr_load = tmr_done || to_inhibit;
         LOW, GAP:      tmr_load = tmr_done;
         INHIBIT:       tmr_load = tmr_done || !ps2clk_i;
         default:       tmr_load = 1'b0;
      endcase
   end

   ps2_bit_timer #(
      .HALF (HALF)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (tmr_load),
      .done  (tmr_done),
      .first (tmr_first)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         key_ready <= 1'b1;
         ps2clk_o  <= 1'b1;
         ps2data_o <= 1'b1;
         abort_cnt <= 8'd0;
         q[0]      <= 8'd0;
         q[1]      <= 8'd0;
         q[2]      <= 8'd0;
         q_len     <= 2'd0;
         q_ptr     <= 2'd0;
         sh        <= 11'd0;
         bit_idx   <= 4'd0;
         low_seen  <= 1'b0;
         phase_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  key_ready <= 1'b0;
                  q_ptr     <= 2'd0;
                  unique case ({key_ext, key_break})
                     2'b00: begin q[0] <= key_code; q_len <= 2'd1; end
                     2'b10: begin q[0] <= PS2_EXT; q[1] <= key_code; q_len <= 2'd2; end
                     2'b01: begin q[0] <= PS2_BRK; q[1] <= key_code; q_len <= 2'd2; end
                     default: begin
                        q[0] <= PS2_EXT; q[1] <= PS2_BRK; q[2] <= key_code; q_len <= 2'd3;
                     end
                  endcase
                  if (ps2clk_i) state <= LOAD;
               end else if (!key_ready && ps2clk_i) begin
                  state <= LOAD;
               end
            end
            LOAD: begin
               sh        <= ps2_frame(head);
               bit_idx   <= 4'd0;
               low_seen  <= 1'b0;
               ps2clk_o  <= 1'b1;
               ps2data_o <= 1'b0;
               state     <= HIGH;
            end
            HIGH: begin
               if (to_inhibit) begin
                  ps2clk_o  <= 1'b1;
                  ps2data_o <= 1'b1;
                  phase_cnt <= '0;
                  if (abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 8'd1;
                  state     <= INHIBIT;
               end else begin
                  if (!tmr_first) low_seen <= !ps2clk_i;
                  if (tmr_done) begin
                     ps2clk_o <= 1'b0;
                     state    <= LOW;
                  end
               end
            end
            LOW: begin
               if (tmr_done) begin
                  if (bit_idx == 4'(PS2_FRAME_BITS - 1)) begin
                     ps2clk_o  <= 1'b1;
                     ps2data_o <= 1'b1;
                     q_ptr     <= q_ptr + 2'd1;
                     phase_cnt <= '0;
                     if (GAP_BITS != 0) begin
                        state <= GAP;
                     end else if ((q_ptr + 2'd1) != q_len) begin
                        state <= LOAD;
                     end else begin
                        state     <= IDLE;
                        key_ready <= 1'b1;
                        q_ptr     <= 2'd0;
                        q_len     <= 2'd0;
                     end
                  end else begin
                     sh        <= {1'b0, sh[10:1]};
                     ps2data_o <= sh[1];
                     bit_idx   <= bit_idx + 4'd1;
                     ps2clk_o  <= 1'b1;
                     low_seen  <= 1'b0;
                     state     <= HIGH;
                  end
               end
            end
            GAP: begin
               if (tmr_done) begin
                  if (phase_cnt == PH_W'(GAP_PHASES - 1)) begin
                     if (q_ptr != q_len) begin
                        state <= LOAD;
                     end else begin
                        state     <= IDLE;
                        key_ready <= 1'b1;
                        q_ptr     <= 2'd0;
                        q_len     <= 2'd0;
                     end
                  end else begin
                     phase_cnt <= phase_cnt + 1'b1;
                  end
               end
            end
            INHIBIT: begin
               // Two clean timer phases of released clock before resending the same byte
               if (!ps2clk_i) begin
                  phase_cnt <= '0;
               end else if (tmr_done) begin
                  if (phase_cnt == PH_W'(1)) state <= LOAD;
                  else                      phase_cnt <= PH_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_sender.sv
`default_nettype none
`timescale 1ns/1ps
// +-------------------------------------------------------------------+
// | tb_ps2_key_sender : scoreboard bench with PS/2 host decoder       |
// | Rev 1.0                                                           |
// +-------------------------------------------------------------------+
module tb_ps2_key_sender;

   logic       clk = 1'b0;
   logic       reset;
   logic       key_valid;
   logic       key_ready;
   logic [7:0] key_code;
   logic       key_ext;
   logic       key_break;
   logic       host_clk;
   logic       ps2clk_i;
   logic       ps2clk_o;
   logic       ps2data_o;
   logic [7:0] abort_cnt;

   int tests = 0;
   int fails = 0;

   logic [7:0]  exp_q [$];
   int          falls = 0;
   int          decoded = 0;
   int          last_lead = 0;
   logic [10:0] last_frame = '0;

   always #5 clk = ~clk;

   // open-collector bus: the host can only pull the clock low
   assign ps2clk_i = ps2clk_o & host_clk;

   ps2_key_sender #(
      .CLK_HZ   (1000),
      .PS2_HZ   (100),
      .GAP_BITS (2)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_code  (key_code),
      .key_ext   (key_ext),
      .key_break (key_break),
      .ps2clk_i  (ps2clk_i),
      .ps2clk_o  (ps2clk_o),
      .ps2data_o (ps2data_o),
      .abort_cnt (abort_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Host model: samples data on each falling clock edge, checks bit timing and framing
   initial begin
      logic        prev_clk;
      int          bitcnt;
      int          low_len;
      int          high_len;
      logic [10:0] fr;
      logic        fmt_ok;
      prev_clk = 1'b1; bitcnt = 0; low_len = 0; high_len = 0; fr = '0;
      forever begin
         @(negedge clk);
         if (reset !== 1'b0) begin
            prev_clk = 1'b1; bitcnt = 0; low_len = 0; high_len = 0;
         end else begin
            if (prev_clk && !ps2clk_o) begin
               falls++;
               if (bitcnt > 0) check("high_phase", high_len, 5);
               else            last_lead = high_len;
               fr[bitcnt] = ps2data_o;
               bitcnt++;
               low_len  = 1;
               high_len = 0;
               if (bitcnt == 11) begin
                  last_frame = fr;
                  fmt_ok = (fr[0] == 1'b0) && (fr[10] == 1'b1) && ((^fr[9:1]) == 1'b1);
                  check("frame_format", fmt_ok, 1);
                  if (exp_q.size() == 0) begin
                     tests++;
                     fails++;
                     $display("FAIL unexpected_frame: got %0h expected none", fr[8:1]);
                  end else begin
                     check("frame_byte", fr[8:1], exp_q.pop_front());
                  end
                  decoded++;
                  bitcnt = 0;
               end
            end else if (!prev_clk && ps2clk_o) begin
               check("low_phase", low_len, 5);
               high_len = 1;
            end else if (ps2clk_o) begin
               high_len++;
               if (bitcnt > 0 && high_len > 8) bitcnt = 0;
            end else begin
               low_len++;
            end
            prev_clk = ps2clk_o;
         end
      end
   end

   task automatic send(input logic [7:0] code, input logic ext, input logic brk);
      @(posedge clk); #1;
      key_code = code; key_ext = ext; key_break = brk; key_valid = 1'b1;
      @(posedge clk); #1;
      key_valid = 1'b0;
      key_code = 8'hAA; key_ext = 1'b1; key_break = 1'b1;
   endtask

   task automatic wait_ready(input string name, input int budget, output int n);
      n = 0;
      @(negedge clk);
      while (!key_ready && n < budget) begin
         n++;
         @(negedge clk);
      end
      if (!key_ready) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: got ready=0 expected ready=1 within %0d cycles", name, budget);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000 ns");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int f0;
      reset = 1'b1; key_valid = 1'b0; key_code = 8'h00; key_ext = 1'b0; key_break = 1'b0;
      host_clk = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_ready", key_ready, 1);
      check("rst_clk", ps2clk_o, 1);
      check("rst_data", ps2data_o, 1);
      check("rst_abort", abort_cnt, 0);
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("idle_ready", key_ready, 1);

      // make B: 0x32 -> {stop 1, parity 0, 0011_0010, start 0}
      exp_q.push_back(8'h32);
      send(8'h32, 1'b0, 1'b0);
      wait_ready("make", 400, n);
      check("make_latency", n, 131);
      check("make_frame_bits", last_frame, 11'b1_0_0011_0010_0);
      check("make_count", decoded, 1);

      // break Enter: F0 then 5A, lead before 2nd frame = gap 20 + load 1 + high 5
      exp_q.push_back(8'hF0);
      exp_q.push_back(8'h5A);
      send(8'h5A, 1'b0, 1'b1);
      wait_ready("break", 600, n);
      check("break_latency", n, 262);
      check("break_gap_lead", last_lead, 26);
      check("break_count", decoded, 3);

      // extended make with stray requests while busy
      exp_q.push_back(8'hE0);
      exp_q.push_back(8'h75);
      send(8'h75, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         repeat (30) @(posedge clk);
         #1 key_code = 8'h11; key_ext = 1'b0; key_break = 1'b1; key_valid = 1'b1;
         @(posedge clk); #1 key_valid = 1'b0;
      end
      wait_ready("ext", 400, n);
      repeat (40) @(negedge clk);
      check("ext_count", decoded, 5);
      check("ext_ready", key_ready, 1);

      // host inhibit during HIGH of bit 4 (HIGH of bit k starts k*10+1 edges after accept)
      exp_q.push_back(8'h32);
      send(8'h32, 1'b0, 1'b0);
      repeat (41) @(posedge clk);
      #1 host_clk = 1'b0;
      repeat (4) @(posedge clk);
      #1 host_clk = 1'b1;
      @(negedge clk);
      check("inhibit_clk_released", ps2clk_o, 1);
      check("inhibit_data_released", ps2data_o, 1);
      check("inhibit_abort", abort_cnt, 1);
      wait_ready("inhibit", 600, n);
      check("inhibit_count", decoded, 6);
      check("inhibit_abort_final", abort_cnt, 1);

      // reset inside HIGH of bit 6 of 0x1C (bit 6 = d5 = 0)
      send(8'h1C, 1'b0, 1'b0);
      repeat (61) @(posedge clk);
      @(negedge clk);
      check("pre_rst_clk", ps2clk_o, 1);
      check("pre_rst_data", ps2data_o, 0);
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check("midrst_clk", ps2clk_o, 1);
      check("midrst_data", ps2data_o, 1);
      check("midrst_ready", key_ready, 1);
      check("midrst_abort", abort_cnt, 0);
      repeat (15) @(negedge clk);
      exp_q.push_back(8'h1C);
      send(8'h1C, 1'b0, 1'b0);
      wait_ready("post_rst", 400, n);
      check("post_rst_latency", n, 131);
      check("post_rst_count", decoded, 7);

      // host holds clock low while idle: request waits without any clock edge
      @(posedge clk); #1 host_clk = 1'b0;
      repeat (3) @(posedge clk);
      exp_q.push_back(8'h29);
      send(8'h29, 1'b0, 1'b0);
      f0 = falls;
      repeat (30) @(negedge clk);
      check("held_no_edges", falls - f0, 0);
      check("held_not_ready", key_ready, 0);
      @(posedge clk); #1 host_clk = 1'b1;
      wait_ready("held", 400, n);
      check("held_count", decoded, 8);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
